// File: rtl/imm_encoder_if.sv
// Stream bundle for the immediate encoder: request side (in_*) and encoded-word side (out_*).
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output in_valid, imm_sel, imm, base, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, imm_sel, imm, base, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs an immediate into the RISC-V field positions of a template instruction,
// with one capture stage, a small output FIFO and handshake statistics.
module imm_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    localparam logic [2:0] SEL_S     = 3'd0;
    localparam logic [2:0] SEL_B     = 3'd1;
    localparam logic [2:0] SEL_U     = 3'd2;
    localparam logic [2:0] SEL_J     = 3'd3;
    localparam logic [2:0] SEL_I     = 3'd4;
    localparam logic [2:0] SEL_ISTAR = 3'd5;
    localparam logic [2:0] SEL_CSR   = 3'd6;

    logic        s1_valid;
    logic [2:0]  s1_sel;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;

    logic [31:0] pack_inst;
    logic        pack_err;

    logic [32:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop, in_fire;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push    = s1_valid && !full;
    assign pop     = !empty && bus.out_ready;
    assign in_fire = bus.in_valid && bus.in_ready;

    // Full is taken before any same-cycle pop, so this never looks at out_ready.
    assign bus.in_ready  = !s1_valid || !full;
    assign bus.out_valid = !empty;
    assign bus.out_inst  = empty ? '0 : mem[rd_ptr][31:0];
    assign bus.out_err   = !empty && mem[rd_ptr][32];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sel   <= '0;
            s1_imm   <= '0;
            s1_base  <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_sel   <= bus.imm_sel;
            s1_imm   <= bus.imm;
            s1_base  <= bus.base;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: outputs get a default before the case so no path can infer a latch.
    always_comb begin
        pack_inst = s1_base;
        pack_err  = 1'b0;
        case (s1_sel)
            SEL_I: begin
                pack_inst[31:20] = s1_imm[11:0];
                pack_err = !(&s1_imm[31:11] || ~|s1_imm[31:11]);
            end
            SEL_ISTAR: begin
                pack_inst[24:20] = s1_imm[4:0];
                pack_err = |s1_imm[31:5];
            end
            SEL_S: begin
                pack_inst[31:25] = s1_imm[11:5];
                pack_inst[11:7]  = s1_imm[4:0];
                pack_err = !(&s1_imm[31:11] || ~|s1_imm[31:11]);
            end
            SEL_B: begin
                pack_inst[31]    = s1_imm[12];
                pack_inst[7]     = s1_imm[11];
                pack_inst[30:25] = s1_imm[10:5];
                pack_inst[11:8]  = s1_imm[4:1];
                pack_err = s1_imm[0] || !(&s1_imm[31:12] || ~|s1_imm[31:12]);
            end
            SEL_U: begin
                pack_inst[31:12] = s1_imm[31:12];
                pack_err = |s1_imm[11:0];
            end
            SEL_J: begin
                pack_inst[31]    = s1_imm[20];
                pack_inst[30:21] = s1_imm[10:1];
                pack_inst[20]    = s1_imm[11];
                pack_inst[19:12] = s1_imm[19:12];
                pack_err = s1_imm[0] || !(&s1_imm[31:20] || ~|s1_imm[31:20]);
            end
            SEL_CSR: begin
                pack_inst[19:15] = s1_imm[4:0];
                pack_err = |s1_imm[31:5];
            end
            default: pack_err = 1'b1;
        endcase
    end

    // NOTE: FIFO storage is not reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pack_err, pack_inst};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (pop) begin
            enc_count <= enc_count + CNT_W'(1);
            if (mem[rd_ptr][32]) err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed format vectors, backpressure,
// mid-flight reset and a randomized stream against an arithmetic reference model.
module tb_imm_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [CNT_W-1:0] enc_count, err_count;

    always #5 clk = ~clk;

    imm_encoder_if bus ();

    imm_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [31:0] base;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } rsp_t;

    int total = 0;
    int bad   = 0;
    int exp_enc = 0;
    int exp_err = 0;

    // Reference: range checks on the signed value, packing with masks and shifts.
    function automatic rsp_t model(input req_t r);
        rsp_t   o;
        longint s;
        s = longint'($signed(r.imm));
        o.inst = r.base;
        o.err  = 1'b0;
        case (r.sel)
            3'd4: begin
                o.err  = (s < -2048) || (s > 2047);
                o.inst = (r.base & 32'h000F_FFFF) | (r.imm << 20);
            end
            3'd5: begin
                o.err  = (r.imm > 32'd31);
                o.inst = (r.base & 32'hFE0F_FFFF) | ((r.imm & 32'h1F) << 20);
            end
            3'd0: begin
                o.err  = (s < -2048) || (s > 2047);
                o.inst = (r.base & 32'h01FF_F07F) | (((r.imm >> 5) & 32'h7F) << 25)
                       | ((r.imm & 32'h1F) << 7);
            end
            3'd1: begin
                o.err  = ((r.imm % 2) != 0) || (s < -4096) || (s > 4095);
                o.inst = (r.base & 32'h01FF_F07F) | (((r.imm >> 12) & 32'h1) << 31)
                       | (((r.imm >> 5) & 32'h3F) << 25) | (((r.imm >> 1) & 32'hF) << 8)
                       | (((r.imm >> 11) & 32'h1) << 7);
            end
            3'd2: begin
                o.err  = (r.imm % 4096) != 0;
                o.inst = (r.base & 32'h0000_0FFF) | (r.imm & 32'hFFFF_F000);
            end
            3'd3: begin
                o.err  = ((r.imm % 2) != 0) || (s < -(64'sd1 <<< 20)) || (s > (64'sd1 <<< 20) - 1);
                o.inst = (r.base & 32'h0000_0FFF) | (((r.imm >> 20) & 32'h1) << 31)
                       | (((r.imm >> 1) & 32'h3FF) << 21) | (((r.imm >> 11) & 32'h1) << 20)
                       | (r.imm & 32'h000F_F000);
            end
            3'd6: begin
                o.err  = (r.imm > 32'd31);
                o.inst = (r.base & 32'hFFF0_7FFF) | ((r.imm & 32'h1F) << 15);
            end
            default: o.err = 1'b1;
        endcase
        return o;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.sel  = 3'($urandom_range(0, 7));
        r.base = $urandom;
        case ($urandom_range(0, 3))
            0:       r.imm = $urandom;
            1:       r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       r.imm = $urandom & 32'hFFFF_F000;
            default: r.imm = 32'($urandom_range(0, 63));
        endcase
        return r;
    endfunction

    task automatic check_counters(input string name);
        total++;
        if (enc_count !== CNT_W'(exp_enc) || err_count !== CNT_W'(exp_err)) begin
            bad++;
            $display("FAIL %s_counters: enc=%0d err=%0d required enc=%0d err=%0d",
                     name, enc_count, err_count, exp_enc, exp_err);
        end
    endtask

    // One request into an idle encoder; checks acceptance, two-edge latency and the word.
    task automatic send_one(input string name, input logic [2:0] sel, input logic [31:0] imm,
                            input logic [31:0] base, input logic [31:0] exp_inst, input logic exp_e);
        bus.out_ready = 1'b1;
        bus.imm_sel   = sel;
        bus.imm       = imm;
        bus.base      = base;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_accept: in_ready=%b required 1", name, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_early: out_valid=%b one edge after accept, required 0", name, bus.out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_inst !== exp_inst || bus.out_err !== exp_e) begin
            bad++;
            $display("FAIL %s_word: valid=%b inst=%h err=%b required valid=1 inst=%h err=%b",
                     name, bus.out_valid, bus.out_inst, bus.out_err, exp_inst, exp_e);
        end
        @(posedge clk); #1;
        exp_enc++;
        if (exp_e) exp_err++;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.imm_sel   = '0;
        bus.imm       = '0;
        bus.base      = '0;
        reset = 1'b1;
        #12;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0 || bus.out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b inst=%h err=%b required 1 0 00000000 0",
                     bus.in_ready, bus.out_valid, bus.out_inst, bus.out_err);
        end
        check_counters("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_formats();
        send_one("i_neg1",  3'd4, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        send_one("b_8",     3'd1, 32'h0000_0008, 32'h0000_0063, 32'h0000_0463, 1'b0);
        send_one("b_odd",   3'd1, 32'h0000_0009, 32'h0000_0063, 32'h0000_0463, 1'b1);
        check_counters("b_odd_drain");
        send_one("u",       3'd2, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        send_one("j_m4",    3'd3, 32'hFFFF_FFFC, 32'h0000_006F, 32'hFFDF_F06F, 1'b0);
        send_one("i_range", 3'd4, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
        send_one("istar",   3'd5, 32'h0000_0005, 32'h4000_5013, 32'h4050_5013, 1'b0);
        send_one("illegal", 3'd7, 32'h0000_0123, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        send_one("csr",     3'd6, 32'h0000_001F, 32'h3000_2073, 32'h300F_A073, 1'b0);
        send_one("s_m1",    3'd0, 32'hFFFF_FFFF, 32'h0000_0023, 32'hFE00_0FA3, 1'b0);
        check_counters("formats");
    endtask

    task automatic test_back_to_back();
        req_t r [4];
        rsp_t e [4];
        int   acc = 0;
        for (int i = 0; i < 4; i++) begin
            r[i] = rand_req();
            e[i] = model(r[i]);
        end
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (acc < 4) begin
                bus.in_valid = 1'b1;
                bus.imm_sel  = r[acc].sel;
                bus.imm      = r[acc].imm;
                bus.base     = r[acc].base;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        total++;
        if (acc != 3 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_capacity: accepted=%0d in_ready=%b required 3 and 0", acc, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_inst !== e[k].inst || bus.out_err !== e[k].err) begin
                bad++;
                $display("FAIL b2b_drain%0d: valid=%b inst=%h err=%b required valid=1 inst=%h err=%b",
                         k, bus.out_valid, bus.out_inst, bus.out_err, e[k].inst, e[k].err);
            end
            @(posedge clk); #1;
            exp_enc++;
            if (e[k].err) exp_err++;
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_empty: out_valid=%b after drain, required 0", bus.out_valid);
        end
        check_counters("b2b_drain");
        send_one("b2b_fourth", r[3].sel, r[3].imm, r[3].base, e[3].inst, e[3].err);
    endtask

    task automatic test_reset_midflight();
        int acc = 0;
        int stale = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (acc < 2);
            bus.imm_sel  = 3'd4;
            bus.imm      = 32'(c);
            bus.base     = 32'h0000_0013;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        total++;
        if (acc != 2 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_setup: accepted=%0d out_valid=%b required 2 and 1", acc, bus.out_valid);
        end
        #1 reset = 1'b1;
        #1;
        exp_enc = 0;
        exp_err = 0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_inst !== 32'h0) begin
            bad++;
            $display("FAIL midrst_outputs: out_valid=%b in_ready=%b inst=%h required 0 1 00000000",
                     bus.out_valid, bus.in_ready, bus.out_inst);
        end
        check_counters("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL midrst_stale: %0d cycles with out_valid=1 after reset, required 0", stale);
        end
        check_counters("midrst_after");
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int n, input int ready_pct);
        req_t req_q [$];
        rsp_t exp_q [$];
        rsp_t e;
        int   cyc = 0;
        for (int i = 0; i < n; i++) req_q.push_back(rand_req());
        while ((req_q.size() > 0 || exp_q.size() > 0) && cyc < 20 * n + 100) begin
            if (req_q.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.imm_sel  = req_q[0].sel;
                bus.imm      = req_q[0].imm;
                bus.base     = req_q[0].base;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra: inst=%h err=%b with no word expected", bus.out_inst, bus.out_err);
                end else begin
                    e = exp_q.pop_front();
                    exp_enc++;
                    if (e.err) exp_err++;
                    if (bus.out_inst !== e.inst || bus.out_err !== e.err) begin
                        bad++;
                        $display("FAIL rand_word: inst=%h err=%b required inst=%h err=%b",
                                 bus.out_inst, bus.out_err, e.inst, e.err);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model(req_q.pop_front()));
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (req_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rand_timeout: %0d requests and %0d words outstanding, required 0 and 0",
                     req_q.size(), exp_q.size());
        end
        check_counters("rand");
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_random(150, 60);
        test_random(100, 100);
        test_reset_midflight();
        test_random(80, 35);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate generator. Takes a 32-bit immediate and an instruction template, and packs the immediate into the RISC-V bit positions selected by imm_sel.
- Produces a complete instruction word, plus an error flag when the immediate cannot be represented in that format.
- Used by the boot/test instruction-injection path and by the assembler-style self-test stimulus generator.
- Uses a valid/ready stream with one pack stage and an output FIFO.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the statistics counters

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid&&in_ready
- imm_sel  input  3  S=0, B=1, U=2, J=3, I=4, I_star=5, CSR=6; 7 is illegal
- imm  input  32  immediate value (byte offset for B/J, full value for U)
- base  input  32  template holding opcode/rd/rs1/rs2/funct; immediate-field bits are ignored
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer ready
- out_inst  output  32  encoded instruction
- out_err  output  1  immediate not representable, or illegal imm_sel
- enc_count  output  CNT_W  output handshakes completed, wrapping
- err_count  output  CNT_W  output handshakes with out_err=1, wrapping

Behaviour:
Reset:
- Asynchronous reset clears the stage-1 valid, the FIFO pointers and occupancy, and both counters.
- in_ready=1, out_valid=0, out_inst=0, out_err=0 while reset is high.
- Reset asserted mid-operation discards all in-flight entries. No partial output is produced.

Stage 1 (capture):
- On an input handshake, register {imm_sel, imm, base} and set s1_valid.
- in_ready = !s1_valid || !fifo_full.
- in_ready has no combinational dependence on out_ready.

Pack (combinational from stage-1 registers):
- out = base with the format's field bits replaced by immediate bits. All other bits come from base.
  - I: [31:20]=imm[11:0]
  - I_star: [24:20]=imm[4:0]; [31:25] kept from base (funct7)
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - CSR: [19:15]=imm[4:0]
  - illegal (7): base unchanged

Error rules (err=1 when):
- I, S: imm[31:11] not all equal.
- B: imm[0]=1, or imm[31:12] not all equal.
- J: imm[0]=1, or imm[31:20] not all equal.
- U: imm[11:0]≠0.
- I_star, CSR: imm[31:5]≠0.
- imm_sel=7.
- An erroring word is still emitted, packed from the truncated bits.

FIFO:
- Stage 1 pushes {err, inst} when s1_valid && !fifo_full. s1_valid clears unless a new input is accepted in the same cycle.
- out_valid = !fifo_empty. out_inst and out_err come from the head entry.
- Pop on out_valid && out_ready.
- Push and pop in the same cycle: occupancy unchanged.
- Full is evaluated before the same-cycle pop, so no push occurs into a full FIFO even if it pops that cycle.
- Pointers wrap modulo DEPTH.
- Order is strictly preserved.

Latency and capacity:
- Input handshake at edge N → out_valid at edge N+2 when the FIFO is empty.
- Throughput is 1/cycle with out_ready held high.
- Total capacity is DEPTH+1 (FIFO plus stage 1).

Counters:
- enc_count increments on each output handshake.
- err_count increments on each output handshake where out_err=1.
- Both wrap at 2^CNT_W.

Test Plan:
- I, imm=0xFFFFFFFF, base=0x00000013 → out_inst=0xFFF00013, err=0, out_valid two cycles after accept.
- B, imm=0x00000008, base=0x00000063 → 0x00000463. B, imm=0x00000009 → err=1; err_count increments on drain.
- U, imm=0x12345000, base=0x00000037 → 0x12345037. J, imm=0xFFFFFFFC, base=0x0000006F → 0xFFDFF06F.
- I, imm=0x00000800 → err=1. I_star, imm=5, base=0x40005013 → 0x40505013, err=0. imm_sel=7 → inst=base, err=1.
- out_ready=0, 4 back-to-back requests:
  - 3 are accepted, then in_ready=0.
  - Raising out_ready drains them in order, with one output per cycle.
  - enc_count=3 after the drain, then the 4th request is accepted.
- Assert reset with 2 entries queued → out_valid=0, in_ready=1 immediately, counters 0. No stale words appear afterwards.
